// File: rtl/seven_seg_scan_driver_if.sv
// Bus between game-state logic and the seven-segment scan driver.
// Optional macro SSD_BLINK_EN adds the blink_mask field.
interface seven_seg_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  // load is a one-cycle capture qualifier with no ready: every load=1 edge is accepted.
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   dp_mask;
  logic [N_DIGITS-1:0]   blank_mask;
`ifdef SSD_BLINK_EN
  logic [N_DIGITS-1:0]   blink_mask;
`endif
  logic                  load;
  logic [7:0]            seg;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_tick;

`ifdef SSD_BLINK_EN
  modport master (output digits, dp_mask, blank_mask, blink_mask, load,
                  input  seg, an, frame_tick);
  modport slave  (input  digits, dp_mask, blank_mask, blink_mask, load,
                  output seg, an, frame_tick);
`else
  modport master (output digits, dp_mask, blank_mask, load,
                  input  seg, an, frame_tick);
  modport slave  (input  digits, dp_mask, blank_mask, load,
                  output seg, an, frame_tick);
`endif
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with tear-free frame latching.
// Optional macro SSD_BLINK_EN enables per-digit blinking driven by a frame counter.
module seven_seg_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                   clk_display,
  input  logic                   rst,
  seven_seg_scan_driver_if.slave bus
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  if (N_DIGITS < 1 || N_DIGITS > 8 || SCAN_DIV < 2 || BLANK_CYCLES < 0 ||
      BLANK_CYCLES >= SCAN_DIV || BLINK_FRAMES < 1) begin : g_bad_params
    $error("seven_seg_scan_driver: parameter out of range");
  end

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  wrap;
  logic                  frame_tick_q;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  lit;
  logic                  blink_dark;

  logic [4*N_DIGITS-1:0] digit_stg, digit_sh;
  logic [N_DIGITS-1:0]   dp_stg, dp_sh;
  logic [N_DIGITS-1:0]   blank_stg, blank_sh;
  logic                  pending;

  assign wrap = (cnt == LAST_CNT) && (idx == LAST_IDX);

  always_ff @(posedge clk_display) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= wrap;
      if (cnt == LAST_CNT) begin
        cnt <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Shadow only changes at the frame wrap so a frame never mixes old and new values;
  // a load coinciding with the wrap bypasses staging and lands in shadow directly.
  always_ff @(posedge clk_display) begin
    if (rst) begin
      digit_stg <= '0;
      dp_stg    <= '0;
      blank_stg <= '0;
      digit_sh  <= '0;
      dp_sh     <= '0;
      blank_sh  <= '0;
      pending   <= 1'b0;
    end else if (wrap) begin
      pending <= 1'b0;
      if (bus.load) begin
        digit_sh <= bus.digits;
        dp_sh    <= bus.dp_mask;
        blank_sh <= bus.blank_mask;
      end else if (pending) begin
        digit_sh <= digit_stg;
        dp_sh    <= dp_stg;
        blank_sh <= blank_stg;
      end
    end else if (bus.load) begin
      digit_stg <= bus.digits;
      dp_stg    <= bus.dp_mask;
      blank_stg <= bus.blank_mask;
      pending   <= 1'b1;
    end
  end

`ifdef SSD_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);

  logic [N_DIGITS-1:0] blink_stg, blink_sh;
  logic [FW-1:0]       frame_cnt;
  logic                blink_phase;

  always_ff @(posedge clk_display) begin
    if (rst) begin
      blink_stg <= '0;
      blink_sh  <= '0;
    end else if (wrap) begin
      if (bus.load)   blink_sh <= bus.blink_mask;
      else if (pending) blink_sh <= blink_stg;
    end else if (bus.load) begin
      blink_stg <= bus.blink_mask;
    end
  end

  always_ff @(posedge clk_display) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_dark = blink_phase & blink_sh[idx];
`else
  assign blink_dark = 1'b0;
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // Leading blank cycles of each slot keep anodes off while segments settle (anti-ghosting).
  always_comb begin
    lit   = !(cnt < BLANK_END) && !blank_sh[idx] && !blink_dark;
    seg_d = 8'hFF;
    an_d  = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      an_d[i] = !(lit && (idx == IW'(i)));
    end
    if (lit) begin
      seg_d = {~dp_sh[idx], hex_to_seg(digit_sh[{idx, 2'b00} +: 4])};
    end
  end

  always_ff @(posedge clk_display) begin
    if (rst) begin
      seg_q <= 8'hFF;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (N_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1).
// Blink scenario is compiled in only when SSD_BLINK_EN is defined.
module tb_seven_seg_scan_driver;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int FL = N * SD;

  // clock / reset
  logic clk_display = 1'b0;
  logic rst;
  always #5 clk_display = ~clk_display;

  seven_seg_scan_driver_if #(.N_DIGITS(N)) bus ();

  seven_seg_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(1), .BLINK_FRAMES(2)
  ) dut (
    .clk_display(clk_display),
    .rst        (rst),
    .bus        (bus)
  );

  // scoreboard: entries are {frame_tick, an, seg}
  logic [12:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // load plan for the next run_frame: load is raised right after sample ld_k[j]
  int         ld_k  [2];
  logic [15:0] ld_d [2];
  logic [3:0]  ld_dp[2];
  logic [3:0]  ld_bl[2];
  logic [3:0]  ld_bk[2];
  logic [3:0]  dark_extra;

  function automatic logic [12:0] exp_entry(int k, logic [15:0] d, logic [3:0] dp, logic [3:0] bl);
    int         c;
    int         i;
    logic       lit;
    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] nib;
    logic [7:0] code;
    c    = k % SD;
    i    = k / SD;
    lit  = (c >= 1) && !bl[i];
    nib  = d[4*i +: 4];
    code = seg_lut[nib];
    an   = 4'hF;
    seg  = 8'hFF;
    if (lit) begin
      an[i] = 1'b0;
      seg   = {~dp[i], code[6:0]};
    end
    return {(k == FL - 1), an, seg};
  endfunction

  task automatic clear_plan();
    for (int j = 0; j < 2; j++) begin
      ld_k[j] = 0; ld_d[j] = '0; ld_dp[j] = '0; ld_bl[j] = '0; ld_bk[j] = '0;
    end
  endtask

  // Checks one whole frame showing (d, dp, bl) and issues any planned loads during it.
  task automatic run_frame(input string name, input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bl);
    logic [12:0] e;
    logic [12:0] got;
    for (int k = 0; k < FL; k++) exp_q.push_back(exp_entry(k, d, dp, bl | dark_extra));
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk_display);
      e   = exp_q.pop_front();
      got = {bus.frame_tick, bus.an, bus.seg};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s slot %0d: got tick/an/seg %b/%h/%h, expected %b/%h/%h",
                 name, k - 1, got[12], got[11:8], got[7:0], e[12], e[11:8], e[7:0]);
      end
      bus.load = 1'b0;
      for (int j = 0; j < 2; j++) begin
        if (ld_k[j] == k) begin
          bus.load       = 1'b1;
          bus.digits     = ld_d[j];
          bus.dp_mask    = ld_dp[j];
          bus.blank_mask = ld_bl[j];
`ifdef SSD_BLINK_EN
          bus.blink_mask = ld_bk[j];
`endif
        end
      end
    end
    clear_plan();
  endtask

  task automatic check_held(input string name);
    @(negedge clk_display);
    n_tests++;
    if ({bus.frame_tick, bus.an, bus.seg} !== {1'b0, 4'hF, 8'hFF}) begin
      n_fail++;
      $display("FAIL %s: got tick/an/seg %b/%h/%h, expected 0/f/ff",
               name, bus.frame_tick, bus.an, bus.seg);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) check_held("reset_held");
    rst = 1'b0;
    run_frame("reset_frame", 16'h0000, 4'h0, 4'h0);
  endtask

  task automatic test_basic_load();
    ld_k[0] = 5; ld_d[0] = 16'h3210;
    run_frame("pre_load", 16'h0000, 4'h0, 4'h0);
    run_frame("digits_3210", 16'h3210, 4'h0, 4'h0);
  endtask

  task automatic test_mid_frame();
    ld_k[0] = 8; ld_d[0] = 16'h00AF;
    run_frame("mid_frame_old", 16'h3210, 4'h0, 4'h0);
    run_frame("mid_frame_new", 16'h00AF, 4'h0, 4'h0);
  endtask

  task automatic test_masks();
    ld_k[0] = 3; ld_d[0] = 16'hBE90; ld_dp[0] = 4'b0001; ld_bl[0] = 4'b0100;
    run_frame("masks_old", 16'h00AF, 4'h0, 4'h0);
    run_frame("masks_new", 16'hBE90, 4'b0001, 4'b0100);
  endtask

  task automatic test_back_to_back();
    ld_k[0] = FL - 1; ld_d[0] = 16'h1234;
    run_frame("wrap_load_old", 16'hBE90, 4'b0001, 4'b0100);
    ld_k[0] = 6; ld_d[0] = 16'h5678;
    run_frame("wrap_load_new", 16'h1234, 4'h0, 4'h0);
    run_frame("second_load", 16'h5678, 4'h0, 4'h0);
  endtask

  task automatic test_last_wins();
    ld_k[0] = 2;  ld_d[0] = 16'h9ABC; ld_dp[0] = 4'b0101;
    ld_k[1] = 10; ld_d[1] = 16'hDEF0; ld_dp[1] = 4'b1010;
    run_frame("last_wins_old", 16'h5678, 4'h0, 4'h0);
    run_frame("last_wins_new", 16'hDEF0, 4'b1010, 4'h0);
    run_frame("no_new_load", 16'hDEF0, 4'b1010, 4'h0);
  endtask

  task automatic test_random();
    logic [15:0] prev_d, nd;
    logic [3:0]  prev_dp, prev_bl, ndp, nbl;
    prev_d = 16'hDEF0; prev_dp = 4'b1010; prev_bl = 4'h0;
    for (int r = 0; r < 5; r++) begin
      nd  = 16'($urandom);
      ndp = 4'($urandom_range(0, 15));
      nbl = 4'($urandom_range(0, 15));
      ld_k[0] = $urandom_range(1, FL - 2); ld_d[0] = nd; ld_dp[0] = ndp; ld_bl[0] = nbl;
      run_frame("random_old", prev_d, prev_dp, prev_bl);
      prev_d = nd; prev_dp = ndp; prev_bl = nbl;
    end
    run_frame("random_last", prev_d, prev_dp, prev_bl);
  endtask

  task automatic test_reset_mid();
    repeat (6) @(negedge clk_display);
    rst = 1'b1;
    check_held("mid_reset");
    rst = 1'b0;
    run_frame("after_mid_reset", 16'h0000, 4'h0, 4'h0);
  endtask

`ifdef SSD_BLINK_EN
  task automatic test_blink();
    rst = 1'b1;
    check_held("blink_reset");
    rst = 1'b0;
    ld_k[0] = 5; ld_d[0] = 16'h3210; ld_bk[0] = 4'b0001;
    run_frame("blink_f0", 16'h0000, 4'h0, 4'h0);
    run_frame("blink_f1_lit", 16'h3210, 4'h0, 4'h0);
    dark_extra = 4'b0001;
    run_frame("blink_f2_dark", 16'h3210, 4'h0, 4'h0);
    run_frame("blink_f3_dark", 16'h3210, 4'h0, 4'h0);
    dark_extra = 4'b0000;
    run_frame("blink_f4_lit", 16'h3210, 4'h0, 4'h0);
    run_frame("blink_f5_lit", 16'h3210, 4'h0, 4'h0);
    dark_extra = 4'b0001;
    run_frame("blink_f6_dark", 16'h3210, 4'h0, 4'h0);
    dark_extra = 4'b0000;
  endtask
`endif

  initial begin
    rst            = 1'b1;
    bus.load       = 1'b0;
    bus.digits     = '0;
    bus.dp_mask    = '0;
    bus.blank_mask = '0;
`ifdef SSD_BLINK_EN
    bus.blink_mask = '0;
`endif
    dark_extra = 4'b0000;
    clear_plan();

    test_reset();
    test_basic_load();
    test_mid_frame();
    test_masks();
    test_back_to_back();
    test_last_wins();
    test_random();
    test_reset_mid();
`ifdef SSD_BLINK_EN
    test_blink();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
